// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronizes uart_rx, qualifies the start bit at mid-bit and samples
// each data/stop bit at mid-period; one-cycle strobes for a good byte or a framing error.
module uart_receiver #(
  parameter int unsigned BAUD_DIV   = 325,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_status,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int unsigned TW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned SW = $clog2(OVERSAMPLE);

  localparam logic [TW-1:0] TICK_LAST = TW'(BAUD_DIV - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [SW-1:0] MID_LAST  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] BIT_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SAMP_ONE  = SW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, rx_s_q, prev_q;
  logic [TW-1:0] tick_q, tick_d;
  logic [SW-1:0] samp_q, samp_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          status_q, status_d;
  logic          ferr_q, ferr_d;
  logic          start_det;
  logic          tick_hit;

  // prev_q trails rx_s_q by one cycle so a line that stays low cannot re-trigger
  assign start_det = prev_q & ~rx_s_q;
  assign tick_hit  = (tick_q == TICK_LAST);

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    samp_d   = samp_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    data_d   = data_q;
    status_d = 1'b0;
    ferr_d   = 1'b0;

    if (state_q == IDLE) begin
      tick_d = '0;
      samp_d = '0;
      idx_d  = '0;
      if (start_det) begin
        state_d = START;
      end
    end else begin
      tick_d = tick_hit ? '0 : tick_q + TICK_ONE;
      if (tick_hit) begin
        samp_d = samp_q + SAMP_ONE;
      end
      case (state_q)
        START: begin
          if (tick_hit && samp_q == MID_LAST) begin
            samp_d  = '0;
            idx_d   = '0;
            state_d = rx_s_q ? IDLE : DATA;
          end
        end
        DATA: begin
          if (tick_hit && samp_q == BIT_LAST) begin
            samp_d         = '0;
            shift_d[idx_q] = rx_s_q;
            idx_d          = idx_q + 3'd1;
            if (idx_q == 3'd7) begin
              state_d = STOP;
            end
          end
        end
        STOP: begin
          if (tick_hit && samp_q == BIT_LAST) begin
            samp_d  = '0;
            state_d = IDLE;
            if (rx_s_q) begin
              data_d   = shift_q;
              status_d = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= 1'b1;
      rx_s_q   <= 1'b1;
      prev_q   <= 1'b1;
      state_q  <= IDLE;
      tick_q   <= '0;
      samp_q   <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      status_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      sync1_q  <= uart_rx;
      rx_s_q   <= sync1_q;
      prev_q   <= rx_s_q;
      state_q  <= state_d;
      tick_q   <= tick_d;
      samp_q   <= samp_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      status_q <= status_d;
      ferr_q   <= ferr_d;
    end
  end

  assign rx_data      = data_q;
  assign rx_status    = status_q;
  assign rx_frame_err = ferr_q;
  assign rx_busy      = (state_q != IDLE);

endmodule
